uart_tx_v2: RTL and testbench

Byte-wide UART transmitter, 8N1, LSB first, idle-high line. It sits under the print/debug path: the print queue drains into it one byte per handshake, and it serialises each byte onto the board TX pin. Baud timing comes from a clock-divide counter derived from two parameters.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/uart_tx_v2.sv | 104 ++++++++++
 tb/tb_uart_tx_v2.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, frame shape and
// baud divider computation.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_state_e;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned STOP_BITS  = 1;
   localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

   // Integer truncation is intended; the result must be at least 2.
   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Divide-by-CLKS_PER_BIT bit timer; bit_done_o pulses for one cycle on the
// last clock of every bit slot while enabled.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic bit_done_o
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign bit_done_o = en_i && (cnt_q == CntW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = bit_done_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_v2.sv
// 8N1 UART transmitter, LSB first, idle-high. One byte accepted per edge with
// en=1 and busy=0; the frame occupies exactly 10 bit slots of busy.
module uart_tx_v2
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 27_000_000,
   parameter int unsigned BAUD_RATE = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       en,
   output logic       busy,
   output logic       txp
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int unsigned IdxW         = $clog2(DATA_BITS);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
   logic                 txp_q, txp_d;
   logic                 busy_q, busy_d;
   logic                 accept;
   logic                 bit_done;

   assign accept = en && !busy_q;
   assign busy   = busy_q;
   assign txp    = txp_q;

   // Cleared on accept so the start bit gets a full slot from E0.
   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (accept),
      .en_i      (busy_q),
      .bit_done_o(bit_done)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      txp_d     = txp_q;
      busy_d    = busy_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d   = StStart;
               shift_d   = data;
               bit_idx_d = '0;
               txp_d     = 1'b0;
               busy_d    = 1'b1;
            end
         end
         StStart: begin
            if (bit_done) begin
               state_d = StData;
               txp_d   = shift_q[0];
            end
         end
         StData: begin
            if (bit_done) begin
               if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
                  state_d = StStop;
                  txp_d   = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                  txp_d     = shift_q[1];
               end
            end
         end
         StStop: begin
            if (bit_done) begin
               state_d = StIdle;
               busy_d  = 1'b0;
               txp_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_idx_q <= '0;
         txp_q     <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         txp_q     <= txp_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_v2.sv
// Directed bench for uart_tx_v2: one instance at N=4 for frame checks, one at
// default parameters for the 234-cycle bit slot.
module tb_uart_tx_v2;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       en;
   logic       busy;
   logic       txp;
   logic [7:0] data_def;
   logic       en_def;
   logic       busy_def;
   logic       txp_def;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_v2 #(
      .CLK_FREQ (400),
      .BAUD_RATE(100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .data(data),
      .en  (en),
      .busy(busy),
      .txp (txp)
   );

   uart_tx_v2 dut_def (
      .clk (clk),
      .rst (rst),
      .data(data_def),
      .en  (en_def),
      .busy(busy_def),
      .txp (txp_def)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic exp_line(input logic [7:0] d, input int slot);
      logic [7:0] v;
      v = d;
      if (slot == 0) return 1'b0;
      if (slot >= 9) return 1'b1;
      return v[slot-1];
   endfunction

   // Called right after a negedge; pa/pb are edge offsets from E0 at which a
   // stray request with data 8'hFF is pulsed (negative = none).
   task automatic run_frame(input logic [7:0] d, input int pa, input int pb, input string tag);
      data = d;
      en   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int j = 0; j < 40; j++) begin
         check_eq({tag, "_txp"}, 32'(txp), 32'(exp_line(d, j / 4)));
         check_eq({tag, "_busy"}, 32'(busy), 32'd1);
         if (j == pa - 1 || j == pb - 1) begin
            en   = 1'b1;
            data = 8'hFF;
         end else begin
            en = 1'b0;
         end
         @(negedge clk);
      end
      check_eq({tag, "_busy_fall"}, 32'(busy), 32'd0);
      check_eq({tag, "_txp_idle"}, 32'(txp), 32'd1);
   endtask

   logic [7:0] q_bytes [3];
   logic       bsy_s   [160];
   logic       txp_s   [160];
   int         taken   [3];

   initial begin
      int         idx;
      int         stray;
      int         starts[$];
      logic [7:0] dec;
      logic [7:0] dd;

      rst      = 1'b0;
      en       = 1'b0;
      data     = 8'h00;
      en_def   = 1'b0;
      data_def = 8'h00;

      // Asynchronous reset, asserted mid-cycle
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("rst_txp", 32'(txp), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_def_busy", 32'(busy_def), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy !== 1'b0 || txp !== 1'b1) stray++;
      end
      check_eq("rst_idle_hold", 32'(stray), 32'd0);

      // Single byte
      run_frame(8'hA5, -1, -1, "a5");

      // Requests while busy are ignored
      repeat (3) @(negedge clk);
      run_frame(8'h3C, 1, 20, "ign");
      stray = 0;
      repeat (50) begin
         if (busy !== 1'b0 || txp !== 1'b1) stray++;
         @(negedge clk);
      end
      check_eq("ign_no_second_frame", 32'(stray), 32'd0);

      // Back-to-back with caller handshake
      q_bytes = '{8'h00, 8'hFF, 8'h55};
      taken   = '{0, 0, 0};
      idx     = 0;
      for (int i = 0; i < 160; i++) begin
         bsy_s[i] = busy;
         txp_s[i] = txp;
         if (en && busy) begin
            if (idx < 3) taken[idx]++;
            idx++;
         end
         en   = (idx < 3) && !busy;
         data = (idx < 3) ? q_bytes[idx] : 8'h00;
         @(negedge clk);
      end
      en = 1'b0;
      for (int i = 0; i < 160; i++) begin
         if (bsy_s[i] && (i == 0 || !bsy_s[i-1])) starts.push_back(i);
      end
      check_eq("b2b_frames", 32'(starts.size()), 32'd3);
      for (int f = 0; f < 3 && f < starts.size(); f++) begin
         int st;
         int len;
         st  = starts[f];
         len = 0;
         while (st + len < 160 && bsy_s[st+len]) len++;
         check_eq("b2b_busy_len", 32'(len), 32'd40);
         if (st + 40 <= 160) begin
            check_eq("b2b_start_bit", 32'(txp_s[st+1]), 32'd0);
            check_eq("b2b_stop_bit", 32'(txp_s[st+37]), 32'd1);
            for (int k = 0; k < 8; k++) dec[k] = txp_s[st + 4 * (k + 1) + 1];
            check_eq("b2b_byte", 32'(dec), 32'(q_bytes[f]));
         end
         if (f + 1 < starts.size()) begin
            check_eq("b2b_gap_le2", 32'(starts[f+1] - (st + len) <= 2), 32'd1);
            for (int g = st + len; g < starts[f+1]; g++) begin
               check_eq("b2b_gap_high", 32'(txp_s[g]), 32'd1);
            end
         end
      end
      for (int f = 0; f < 3; f++) check_eq("b2b_taken_once", 32'(taken[f]), 32'd1);

      // Reset mid-frame, inside data bit 3
      repeat (3) @(negedge clk);
      dd   = 8'h96;
      data = dd;
      en   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (16) @(negedge clk);
      check_eq("midrst_bit3", 32'(txp), 32'(dd[3]));
      check_eq("midrst_busy_before", 32'(busy), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("midrst_txp", 32'(txp), 32'd1);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      repeat (8) begin
         @(negedge clk);
         if (busy !== 1'b0 || txp !== 1'b1) stray++;
      end
      check_eq("midrst_no_resume", 32'(stray), 32'd0);
      run_frame(8'h5A, -1, -1, "after_rst");

      // Default parameters: N = 234
      dd       = 8'h41;
      data_def = dd;
      en_def   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en_def = 1'b0;
      for (int j = 0; j < 2340; j++) begin
         if (j % 234 == 0 || j % 234 == 233) begin
            check_eq("def_txp", 32'(txp_def), 32'(exp_line(dd, j / 234)));
            check_eq("def_busy", 32'(busy_def), 32'd1);
         end
         @(negedge clk);
      end
      check_eq("def_busy_fall", 32'(busy_def), 32'd0);
      check_eq("def_txp_idle", 32'(txp_def), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
